// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS main control FSM:
//   state encoding, opcode constants, datapath select encodings and the
//   packed control-strobe bundle that the output decoder produces.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int OP_W_DEF    = 6;
    localparam int STATE_W_DEF = 4;

    // Encoding 4'hF is deliberately left unused; the FSM treats it as illegal
    // and falls back to IDLE.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_RWB    = 4'd8,
        S_ADDI   = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_EXCEPT = 4'd14
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // Write-back select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // Register destination select
    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// ---------------------------------------------------------------------------
// mc_ctrl_outdec
//   Pure combinational decode of FSM state (and latched opcode) into the
//   datapath control strobes. No handshake qualification happens here; the
//   FETCH-state ir_write/pc_write are gated with mem_ready by the parent.
// Ports
//   state_i  : current FSM state
//   op_i     : opcode latched in DECODE (selects beq vs bne in BRANCH)
//   ctrl_o   : packed control strobe bundle
// ---------------------------------------------------------------------------
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_e          state_i,
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ctrl_o.alu_src_b = SRCB_IMMSH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_RTYPE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
            end
            S_ADDI: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_RT;
                ctrl_o.alu_op       = ALUOP_SUB;
                ctrl_o.pc_src       = PCSRC_ALUOUT;
                ctrl_o.pc_write_beq = (op_i == OP_BEQ);
                ctrl_o.pc_write_bne = (op_i == OP_BNE);
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC still holds PC+4 here, which is the link value
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_R31;
                ctrl_o.mem_to_reg = M2R_PC;
            end
            S_EXCEPT: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PCSRC_EXC;
                ctrl_o.illegal_op = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle MIPS main control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB,
//   stalls on the memory ready handshake in FETCH, MEMRD and MEMWR, and
//   routes illegal opcodes to the exception vector.
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   opcode          : IR[31:26], sampled in DECODE only
//   mem_ready       : memory completes the current access this cycle
//   pc_write*       : PC load strobes (unconditional / on zero / on not-zero)
//   i_or_d          : memory address select (0=PC, 1=ALUOut)
//   mem_read/write  : memory request strobes
//   ir_write        : instruction register load
//   reg_dst         : 00=rt, 01=rd, 10=r31
//   mem_to_reg      : 00=ALUOut, 01=MDR, 10=PC
//   reg_write       : register-file write enable
//   alu_src_a/b     : ALU operand selects
//   alu_op          : 00=add, 01=sub, 10=funct-decoded
//   pc_src          : 00=ALU, 01=ALUOut, 10=jump target, 11=exception vector
//   illegal_op      : one-cycle pulse in EXCEPT
//   state_o         : current state for debug
// ---------------------------------------------------------------------------
module mc_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_beq,
    output logic               pc_write_bne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    ctrl_t           dec;
    logic            fetch_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:     state_d = S_RTYPE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_EXCEPT;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything but sw is treated as a load
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTYPE:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_ADDI:   state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BRANCH,
            S_JUMP,
            S_JAL,
            S_EXCEPT: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    mc_ctrl_outdec #(
        .OP_W (OP_W)
    ) u_outdec (
        .state_i (state_q),
        .op_i    (op_q),
        .ctrl_o  (dec)
    );

    // IR and PC only load once the instruction fetch actually completes
    assign fetch_hold = (state_q == S_FETCH) && !mem_ready;

    assign pc_write     = dec.pc_write & ~fetch_hold;
    assign ir_write     = dec.ir_write & ~fetch_hold;
    assign pc_write_beq = dec.pc_write_beq;
    assign pc_write_bne = dec.pc_write_bne;
    assign i_or_d       = dec.i_or_d;
    assign mem_read     = dec.mem_read;
    assign mem_write    = dec.mem_write;
    assign reg_dst      = dec.reg_dst;
    assign mem_to_reg   = dec.mem_to_reg;
    assign reg_write    = dec.reg_write;
    assign alu_src_a    = dec.alu_src_a;
    assign alu_src_b    = dec.alu_src_b;
    assign alu_op       = dec.alu_op;
    assign pc_src       = dec.pc_src;
    assign illegal_op   = dec.illegal_op;
    assign state_o      = state_q;

endmodule
